// File: rtl/rbot_motion_pkg.sv
// Shared motion-control types: move-sequencer state encoding, face index type
// and default mechanical constants for the cube-solving robot.
package rbot_motion_pkg;

  localparam int NUM_MOTORS_DFLT    = 6;
  localparam int STEPS_PER_QTR_DFLT = 50;

  typedef logic [2:0] face_t;

  typedef enum logic [2:0] {
    IDLE,
    DIR_SETUP,
    PULSE_HI,
    PULSE_LO,
    SETTLE
  } state_t;

  // A command is legal when it asks for at least one quarter turn on an existing motor.
  function automatic logic cmd_legal(input face_t face, input logic [1:0] turns,
                                     input int num_motors);
    return (turns != 2'd0) && (int'(face) < num_motors);
  endfunction

endpackage

// File: rtl/tick_enable_gen.sv
// Clock-enable generator: one-cycle tick every CLK_DIV clocks while run is high;
// the count is held at zero whenever run is low so each run starts a fresh phase.
module tick_enable_gen #(
  parameter int CLK_DIV = 31250
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/stepper_move_scheduler.sv
// Executes one face turn at a time: latches a command, sets dir, emits a timed
// step pulse train on the selected motor, then holds for a settle interval.
module stepper_move_scheduler
  import rbot_motion_pkg::*;
#(
  parameter int CLK_DIV       = 31250,
  parameter int STEPS_PER_QTR = STEPS_PER_QTR_DFLT,
  parameter int SETTLE_TICKS  = 40,
  parameter int NUM_MOTORS    = NUM_MOTORS_DFLT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  move_valid,
  output logic                  move_ready,
  input  logic [2:0]            move_face,
  input  logic                  move_dir,
  input  logic [1:0]            move_turns,
  input  logic                  abort,
  output logic [NUM_MOTORS-1:0] step,
  output logic [NUM_MOTORS-1:0] dir,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int STEP_W   = $clog2(3 * STEPS_PER_QTR + 1);
  localparam int SETTLE_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);

  state_t              state;
  face_t               face;
  logic [STEP_W-1:0]   steps_left;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                tick;
  logic                run;
  logic                legal;

  // Dropping run in the abort cycle clears the tick phase, so a command accepted
  // right after an abort still gets a full DIR_SETUP tick.
  assign run        = (state != IDLE) && !abort;
  assign legal      = cmd_legal(move_face, move_turns, NUM_MOTORS);
  assign move_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  tick_enable_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .run  (run),
    .tick (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      face       <= '0;
      steps_left <= '0;
      settle_cnt <= '0;
      step       <= '0;
      dir        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads the
      // pre-edge value of state/steps_left and the defaults here are safely overridden.
      done <= 1'b0;
      err  <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        step  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (move_valid) begin
              if (legal) begin
                face            <= move_face;
                steps_left      <= STEP_W'(int'(move_turns) * STEPS_PER_QTR);
                dir[move_face]  <= move_dir;
                state           <= DIR_SETUP;
              end else begin
                err <= 1'b1;
              end
            end
          end
          DIR_SETUP: begin
            if (tick) begin
              state      <= PULSE_HI;
              step[face] <= 1'b1;
            end
          end
          PULSE_HI: begin
            if (tick) begin
              state      <= PULSE_LO;
              step       <= '0;
              steps_left <= steps_left - 1'b1;
            end
          end
          PULSE_LO: begin
            if (tick) begin
              if (steps_left == '0) begin
                state      <= SETTLE;
                settle_cnt <= '0;
              end else begin
                state      <= PULSE_HI;
                step[face] <= 1'b1;
              end
            end
          end
          SETTLE: begin
            if (tick) begin
              if (settle_cnt == SETTLE_LAST) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                settle_cnt <= settle_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Only one motor may ever be stepping, and only while a pulse is in progress.
  a_step_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(step));
  a_step_only_hi: assert property (@(posedge clock) disable iff (reset)
                                   (state != PULSE_HI) |-> (step == '0));
  a_done_idle: assert property (@(posedge clock) disable iff (reset)
                                done |-> (state == IDLE));

endmodule

// File: doc/stepper_move_scheduler.md
Name: stepper_move_scheduler

Overview:
- Sequences one cube-face quarter/half/three-quarter turn at a time across six stepper motor drivers.
- Accepts a move command over a valid/ready handshake, drives dir, then a timed train of step pulses, then a settle interval.
- Timing comes from an internal clock-enable tick derived from the system clock. No derived clock is used; all logic runs on `clock`.
- Sits between the move-sequence source (solver/command FIFO) and the motor driver pins.

Parameters:
- CLK_DIV, 31250: system clock cycles per tick (25 MHz gives an 800 Hz tick).
- STEPS_PER_QTR, 50: full steps per 90-degree face turn.
- SETTLE_TICKS, 40: ticks of idle hold after the last step before the move completes.
- NUM_MOTORS, 6: number of motor channels. The face index must be less than this.

Ports:
- clock  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- move_valid  in  1  command present.
- move_ready  out  1  block can accept a command.
- move_face  in  3  motor index, 0..NUM_MOTORS-1.
- move_dir  in  1  rotation direction, copied to dir[face].
- move_turns  in  2  quarter turns, 1..3. Value 0 is illegal.
- abort  in  1  synchronous abort of the move in progress.
- step  out  NUM_MOTORS  step pulse per motor.
- dir  out  NUM_MOTORS  direction level per motor, held between moves.
- busy  out  1  move in progress (state not IDLE).
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (async): state=IDLE; step=0; dir=0; done=0; err=0; busy=0; tick counter=0; move_ready=1 after reset deasserts.
- Handshake:
  - move_ready=1 only in IDLE. A command is accepted on an edge where move_valid && move_ready.
  - Inputs are sampled only at acceptance; later changes are ignored.
- Illegal command (move_turns==0 or move_face>=NUM_MOTORS): accepted, no steps issued, dir unchanged. err=1 for the next cycle and state stays IDLE.
- Legal acceptance:
  - Latch face.
  - Load steps_left = move_turns*STEPS_PER_QTR. Width is clog2(3*STEPS_PER_QTR+1); no overflow is possible.
  - dir[face] <= move_dir.
  - Clear the tick counter and enter DIR_SETUP.
- Tick:
  - Counter counts 0..CLK_DIV-1 while busy; tick=1 on the cycle the count equals CLK_DIV-1, then the count wraps to 0.
  - Counter is held at 0 in IDLE.
- State machine (all transitions on tick unless stated):
  - DIR_SETUP -> PULSE_HI. Gives dir at least one tick of setup time before the first step.
  - PULSE_HI: step[face]=1. On tick -> PULSE_LO and steps_left decrements.
  - PULSE_LO: step all 0. On tick: steps_left==0 -> SETTLE, else -> PULSE_HI.
  - SETTLE: counts SETTLE_TICKS ticks, then -> IDLE with done=1 for exactly one cycle. move_ready=1 in that same cycle.
- Step pulses:
  - Each step is high for exactly CLK_DIV cycles and low for CLK_DIV cycles.
  - Only step[face] ever toggles; all other step bits stay 0.
- Latency from the acceptance edge to the done cycle = CLK_DIV*(1 + 2*steps + SETTLE_TICKS).
- Abort:
  - Any non-IDLE state -> IDLE on the next edge; step=0; dir retained; no done, no err.
  - Abort in IDLE is ignored.
  - A simultaneous abort and move_valid while in IDLE accepts the command.
- Async reset mid-move: immediate return to reset values; step drops at once.
- move_valid held high continuously: back-to-back moves.
  - The next command is accepted in the done cycle.
  - No idle gap is required beyond the settle interval.

Decomposition:
- Shared package rbot_motion_pkg holds:
  - the state enum (IDLE, DIR_SETUP, PULSE_HI, PULSE_LO, SETTLE);
  - the NUM_MOTORS and STEPS_PER_QTR defaults;
  - a face-index typedef of 3 bits.
- One sub-module: tick_enable_gen. It is a parameterised CLK_DIV counter with clear input `run` and one-cycle `tick` output, and uses the same clock/reset ports.

Test Plan (CLK_DIV=4, STEPS_PER_QTR=3, SETTLE_TICKS=2 unless stated):
- Legal move: face=2, dir=1, turns=1.
  - dir[2]=1 from the cycle after accept.
  - step[2] shows 3 pulses, each 4 cycles high / 4 low; other step bits stay 0.
  - done 4*(1+6+2)=36 cycles after the accept edge; busy low afterwards.
- Half turn: face=5, dir=0, turns=2 -> 6 pulses on step[5]; done 60 cycles after accept. Repeat with turns=3 -> 9 pulses, 84 cycles.
- Illegal commands: turns=0 -> err pulse the next cycle, no step activity, dir unchanged, move_ready stays 1. face=6 -> same response.
- Abort during the 2nd PULSE_HI of a turns=1 move:
  - step drops the next cycle, state IDLE, no done.
  - A following move runs the full 3 pulses from a fresh tick phase.
- Async reset mid-PULSE_HI: step, dir, busy go to 0 without a clock edge; move_ready=1 after release.
- Back-to-back: move_valid held high with two queued moves (face 0, then face 1).
  - The second move is accepted in the first move's done cycle.
  - dir[0] is retained while face 1 runs.
